alu_control_pipe: RTL and testbench

Registered, parametrised successor to the single-cycle ALU control decoder. Decodes ALUOP/Function into the ALU select code with one cycle of latency and a valid/ready handshake. Adds immediate-class ALUOP decodes, an illegal-op flag, and a multi-cycle sequencer for MULT/DIV. It stalls upstream while the multiply/divide unit runs. Sits between the main control unit (ID stage) and the ALU plus MD unit (EX stage).

---
 rtl/alu_control_pipe_pkg.sv | 46 ++++
 rtl/alu_control_pipe_if.sv | 34 +++
 rtl/alu_control_pipe_md_sequencer.sv | 71 +++++++
 rtl/alu_control_pipe.sv | 104 ++++++++++
 tb/tb_alu_control_pipe.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_control_pipe_pkg.sv
// ALU control pipe shared definitions.
// Op classes, funct codes, ALU selects and MD sequencer states.
package alu_ctrl_pkg;

   localparam logic [2:0] ALUOP_ADDI = 3'b000;
   localparam logic [2:0] ALUOP_SUBI = 3'b001;
   localparam logic [2:0] ALUOP_R    = 3'b010;
   localparam logic [2:0] ALUOP_ANDI = 3'b011;
   localparam logic [2:0] ALUOP_ORI  = 3'b100;
   localparam logic [2:0] ALUOP_SLTI = 3'b101;

   localparam logic [5:0] FUNCT_NOP  = 6'b000000;
   localparam logic [5:0] FUNCT_SRL  = 6'b000010;
   localparam logic [5:0] FUNCT_SRA  = 6'b000011;
   localparam logic [5:0] FUNCT_MULT = 6'b011000;
   localparam logic [5:0] FUNCT_DIV  = 6'b011010;
   localparam logic [5:0] FUNCT_ADD  = 6'b100000;
   localparam logic [5:0] FUNCT_SUB  = 6'b100010;
   localparam logic [5:0] FUNCT_AND  = 6'b100100;
   localparam logic [5:0] FUNCT_OR   = 6'b100101;
   localparam logic [5:0] FUNCT_XOR  = 6'b100110;
   localparam logic [5:0] FUNCT_NOR  = 6'b100111;
   localparam logic [5:0] FUNCT_SLT  = 6'b101010;

   localparam logic [3:0] SEL_ADD = 4'b0000;
   localparam logic [3:0] SEL_SUB = 4'b0001;
   localparam logic [3:0] SEL_SLT = 4'b0011;
   localparam logic [3:0] SEL_AND = 4'b0100;
   localparam logic [3:0] SEL_OR  = 4'b0101;
   localparam logic [3:0] SEL_XOR = 4'b0110;
   localparam logic [3:0] SEL_NOR = 4'b0111;
   localparam logic [3:0] SEL_NOP = 4'b1000;
   localparam logic [3:0] SEL_SRL = 4'b1010;
   localparam logic [3:0] SEL_SRA = 4'b1011;
   localparam logic [3:0] SEL_ILL = 4'b1111;

   localparam logic MD_MULT = 1'b0;
   localparam logic MD_DIV  = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } md_state_t;

endpackage

// File: rtl/alu_control_pipe_if.sv
// ID->EX ALU control bundle.
// master drives ops in; slave returns selects and MD status.
interface alu_control_pipe_if #(
   parameter int ALUOP_W = 3,
   parameter int FUNC_W  = 6,
   parameter int SEL_W   = 4
);
   logic               in_valid;
   logic               in_ready;
   logic [ALUOP_W-1:0] ALUOP;
   logic [FUNC_W-1:0]  Function;
   logic               out_valid;
   logic [SEL_W-1:0]   selecOP;
   logic               illegal;
   logic               illegal_sticky;
   logic               md_start;
   logic               md_op;
   logic               md_busy;
   logic               md_done;

   modport master (
      output in_valid, ALUOP, Function,
      input  in_ready, out_valid, selecOP, illegal,
      input  illegal_sticky, md_start, md_op,
      input  md_busy, md_done
   );

   modport slave (
      input  in_valid, ALUOP, Function,
      output in_ready, out_valid, selecOP, illegal,
      output illegal_sticky, md_start, md_op,
      output md_busy, md_done
   );
endinterface

// File: rtl/alu_control_pipe_md_sequencer.sv
// Multiply/divide sequencer: holds the MD unit busy for
// MD_CYCLES cycles, then issues a one-cycle done.
module alu_md_sequencer
   import alu_ctrl_pkg::*;
#(
   parameter int MD_CYCLES = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic op,
   output logic ready,
   output logic busy,
   output logic start_pulse,
   output logic done,
   output logic op_q
);
   localparam int CW = $clog2(MD_CYCLES + 1);
   localparam logic [CW-1:0] LOAD = CW'(MD_CYCLES - 1);

   md_state_t state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic op_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= '0;
         op_q    <= MD_MULT;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         op_q    <= op_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      op_d        = op_q;
      ready       = 1'b0;
      busy        = 1'b0;
      start_pulse = 1'b0;
      done        = 1'b0;
      unique case (state_q)
         IDLE: begin
            ready = 1'b1;
            if (start) begin
               state_d = RUN;
               count_d = LOAD;
               op_d    = op;
            end
         end
         RUN: begin
            busy = 1'b1;
            // count is still at its load value only in the first RUN cycle
            start_pulse = (count_q == LOAD);
            if (count_q == '0) begin
               state_d = DONE;
            end else begin
               count_d = count_q - CW'(1);
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: rtl/alu_control_pipe.sv
// Registered ALU control decoder with valid/ready handshake
// and a MULT/DIV sequencer that stalls upstream while busy.
module alu_control_pipe
   import alu_ctrl_pkg::*;
#(
   parameter int ALUOP_W   = 3,
   parameter int FUNC_W    = 6,
   parameter int SEL_W     = 4,
   parameter int MD_CYCLES = 32
) (
   input logic clk,
   input logic rst,
   alu_control_pipe_if.slave bus
);
   logic [ALUOP_W-1:0] op;
   logic [FUNC_W-1:0]  fn;
   logic               is_r;
   logic [SEL_W-1:0]   dec_sel;
   logic               dec_ill;
   logic               dec_md;
   logic               dec_op;
   logic               seq_ready;
   logic               accept;
   logic               out_valid_q;
   logic [SEL_W-1:0]   sel_q;
   logic               ill_q;
   logic               sticky_q;

   assign op   = bus.ALUOP;
   assign fn   = bus.Function;
   assign is_r = (op == ALUOP_W'(ALUOP_R));

   always_comb begin
      dec_sel = SEL_W'(SEL_NOP);
      dec_ill = 1'b0;
      dec_md  = 1'b0;
      dec_op  = MD_MULT;
      unique case (1'b1)
         is_r && fn == FUNC_W'(FUNCT_ADD): dec_sel = SEL_W'(SEL_ADD);
         is_r && fn == FUNC_W'(FUNCT_SUB): dec_sel = SEL_W'(SEL_SUB);
         is_r && fn == FUNC_W'(FUNCT_AND): dec_sel = SEL_W'(SEL_AND);
         is_r && fn == FUNC_W'(FUNCT_OR):  dec_sel = SEL_W'(SEL_OR);
         is_r && fn == FUNC_W'(FUNCT_XOR): dec_sel = SEL_W'(SEL_XOR);
         is_r && fn == FUNC_W'(FUNCT_NOR): dec_sel = SEL_W'(SEL_NOR);
         is_r && fn == FUNC_W'(FUNCT_SLT): dec_sel = SEL_W'(SEL_SLT);
         is_r && fn == FUNC_W'(FUNCT_NOP): dec_sel = SEL_W'(SEL_NOP);
         is_r && fn == FUNC_W'(FUNCT_SRL): dec_sel = SEL_W'(SEL_SRL);
         is_r && fn == FUNC_W'(FUNCT_SRA): dec_sel = SEL_W'(SEL_SRA);
         is_r && fn == FUNC_W'(FUNCT_MULT): dec_md = 1'b1;
         is_r && fn == FUNC_W'(FUNCT_DIV): begin
            dec_md = 1'b1;
            dec_op = MD_DIV;
         end
         op == ALUOP_W'(ALUOP_ADDI): dec_sel = SEL_W'(SEL_ADD);
         op == ALUOP_W'(ALUOP_SUBI): dec_sel = SEL_W'(SEL_SUB);
         op == ALUOP_W'(ALUOP_ANDI): dec_sel = SEL_W'(SEL_AND);
         op == ALUOP_W'(ALUOP_ORI):  dec_sel = SEL_W'(SEL_OR);
         op == ALUOP_W'(ALUOP_SLTI): dec_sel = SEL_W'(SEL_SLT);
         default: begin
            dec_sel = SEL_W'(SEL_ILL);
            dec_ill = 1'b1;
         end
      endcase
   end

   // reset masks ready so a coincident in_valid is never taken
   assign bus.in_ready = seq_ready && !rst;
   assign accept       = bus.in_valid && bus.in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         sel_q       <= SEL_W'(SEL_NOP);
         ill_q       <= 1'b0;
         sticky_q    <= 1'b0;
      end else begin
         out_valid_q <= accept;
         if (accept) begin
            sel_q    <= dec_sel;
            ill_q    <= dec_ill;
            sticky_q <= sticky_q | dec_ill;
         end
      end
   end

   assign bus.out_valid      = out_valid_q;
   assign bus.selecOP        = sel_q;
   assign bus.illegal        = ill_q;
   assign bus.illegal_sticky = sticky_q;

   alu_md_sequencer #(
      .MD_CYCLES(MD_CYCLES)
   ) u_md (
      .clk        (clk),
      .rst        (rst),
      .start      (accept && dec_md),
      .op         (dec_op),
      .ready      (seq_ready),
      .busy       (bus.md_busy),
      .start_pulse(bus.md_start),
      .done       (bus.md_done),
      .op_q       (bus.md_op)
   );
endmodule

// File: tb/tb_alu_control_pipe.sv
// Bench for alu_control_pipe: directed steps plus random ops
// against a cycle-indexed reference model.
module tb_alu_control_pipe;
   import alu_ctrl_pkg::*;

   localparam int MD = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   alu_control_pipe_if bus4 ();
   alu_control_pipe_if bus1 ();

   alu_control_pipe #(.MD_CYCLES(MD)) dut4 (
      .clk(clk), .rst(rst), .bus(bus4.slave)
   );
   alu_control_pipe #(.MD_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1.slave)
   );

   int checks = 0;
   int passed = 0;
   int fails  = 0;

   // model: expected registered outputs, MD accept edge, edge count
   logic       exp_ov;
   logic [3:0] exp_sel;
   logic       exp_ill;
   logic       exp_stk;
   logic       exp_mop;
   int         acc_edge = -100;
   int         cyc = 0;

   logic [5:0] r_fn [12] = '{
      6'b100000, 6'b100010, 6'b100100, 6'b100101,
      6'b100110, 6'b100111, 6'b101010, 6'b000010,
      6'b000011, 6'b000000, 6'b011000, 6'b011010
   };
   logic [3:0] r_sel [12] = '{
      4'b0000, 4'b0001, 4'b0100, 4'b0101,
      4'b0110, 4'b0111, 4'b0011, 4'b1010,
      4'b1011, 4'b1000, 4'b1000, 4'b1000
   };
   logic [3:0] i_sel [8] = '{
      4'b0000, 4'b0001, 4'b0000, 4'b0100,
      4'b0101, 4'b0011, 4'b0000, 4'b0000
   };
   logic i_ok [8] = '{1, 1, 0, 1, 1, 1, 0, 0};

   // returns {illegal, is_md, md_op, sel}
   function automatic logic [6:0] ref_op(
      input logic [2:0] op, input logic [5:0] fn
   );
      logic [6:0] r;
      logic md, dv;
      r = {3'b100, 4'b1111};
      if (op == 3'b010) begin
         md = (fn == 6'b011000) || (fn == 6'b011010);
         dv = (fn == 6'b011010);
         for (int i = 0; i < 12; i++)
            if (r_fn[i] == fn) r = {1'b0, md, dv, r_sel[i]};
      end else if (i_ok[op]) begin
         r = {3'b000, i_sel[op]};
      end
      return r;
   endfunction

   task automatic chk(
      input string tag, input logic [7:0] obs, input logic [7:0] exp
   );
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: got %0h want %0h (cycle %0d)",
                tag, obs, exp, cyc);
      end
   endtask

   task automatic check_outs();
      int k;
      k = cyc - acc_edge + 1;
      chk("out_valid", bus4.out_valid, exp_ov);
      chk("selecOP", bus4.selecOP, exp_sel);
      chk("illegal", bus4.illegal, exp_ill);
      chk("illegal_sticky", bus4.illegal_sticky, exp_stk);
      chk("md_start", bus4.md_start, k == 1);
      chk("md_busy", bus4.md_busy, k >= 1 && k <= MD);
      chk("md_done", bus4.md_done, k == MD + 1);
      chk("md_op", bus4.md_op, exp_mop);
   endtask

   task automatic tick(
      input logic v, input logic [2:0] op, input logic [5:0] fn
   );
      logic [6:0] r;
      logic rdy;
      int k;
      bus4.in_valid = v;
      bus4.ALUOP    = op;
      bus4.Function = fn;
      #1;
      k   = cyc - acc_edge + 1;
      rdy = !(k >= 1 && k <= MD + 1);
      chk("in_ready", bus4.in_ready, rdy);
      r = ref_op(op, fn);
      @(posedge clk);
      #1;
      cyc++;
      exp_ov = v && rdy;
      if (v && rdy) begin
         exp_sel = r[3:0];
         exp_ill = r[6];
         exp_stk = exp_stk | r[6];
         if (r[5]) begin
            acc_edge = cyc;
            exp_mop  = r[4];
         end
      end
      check_outs();
   endtask

   task automatic do_reset(input logic v);
      rst = 1'b1;
      bus4.in_valid = v;
      bus4.ALUOP    = 3'b010;
      bus4.Function = 6'b100000;
      bus1.in_valid = v;
      #1;
      chk("in_ready_in_rst", bus4.in_ready, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc++;
      bus4.in_valid = 1'b0;
      bus1.in_valid = 1'b0;
      exp_ov   = 1'b0;
      exp_sel  = 4'b1000;
      exp_ill  = 1'b0;
      exp_stk  = 1'b0;
      exp_mop  = 1'b0;
      acc_edge = -100;
      check_outs();
   endtask

   initial begin
      logic [2:0] op;
      logic [5:0] fn;
      int p;
      bus4.in_valid = 1'b0;
      bus4.ALUOP    = '0;
      bus4.Function = '0;
      bus1.in_valid = 1'b0;
      bus1.ALUOP    = '0;
      bus1.Function = '0;

      // reset with in_valid high: nothing must be accepted
      do_reset(1'b1);

      // back-to-back R-type ops
      for (int i = 0; i < 10; i++) tick(1'b1, 3'b010, r_fn[i]);

      // immediate classes ignore Function
      tick(1'b1, 3'b000, 6'($urandom));
      tick(1'b1, 3'b001, 6'($urandom));
      tick(1'b1, 3'b011, 6'($urandom));
      tick(1'b1, 3'b100, 6'($urandom));
      tick(1'b1, 3'b101, 6'($urandom));
      tick(1'b0, 3'b000, 6'b0);

      // illegal ops and sticky flag
      tick(1'b1, 3'b010, 6'b111111);
      tick(1'b1, 3'b110, 6'($urandom));
      tick(1'b1, 3'b000, 6'b0);
      tick(1'b0, 3'b000, 6'b0);
      do_reset(1'b0);

      // MULT followed by an ADD held until accepted
      tick(1'b1, 3'b010, 6'b011000);
      for (int i = 0; i < 6; i++) tick(1'b1, 3'b010, 6'b100000);
      tick(1'b0, 3'b000, 6'b0);

      // DIV interrupted by reset in its second RUN cycle
      tick(1'b1, 3'b010, 6'b011010);
      tick(1'b0, 3'b000, 6'b0);
      do_reset(1'b0);
      for (int i = 0; i < 7; i++) tick(1'b0, 3'b000, 6'b0);

      // single-cycle MD unit
      bus1.in_valid = 1'b1;
      bus1.ALUOP    = 3'b010;
      bus1.Function = 6'b011010;
      #1;
      chk("md1_ready0", bus1.in_ready, 1'b1);
      tick(1'b0, 3'b000, 6'b0);
      bus1.in_valid = 1'b0;
      chk("md1_out_valid", bus1.out_valid, 1'b1);
      chk("md1_sel", bus1.selecOP, 4'b1000);
      chk("md1_op", bus1.md_op, 1'b1);
      chk("md1_start", bus1.md_start, 1'b1);
      chk("md1_busy", bus1.md_busy, 1'b1);
      chk("md1_done_run", bus1.md_done, 1'b0);
      chk("md1_ready_run", bus1.in_ready, 1'b0);
      tick(1'b0, 3'b000, 6'b0);
      chk("md1_done", bus1.md_done, 1'b1);
      chk("md1_busy_done", bus1.md_busy, 1'b0);
      chk("md1_start_done", bus1.md_start, 1'b0);
      chk("md1_ready_done", bus1.in_ready, 1'b0);
      chk("md1_ov_done", bus1.out_valid, 1'b0);
      tick(1'b0, 3'b000, 6'b0);
      chk("md1_ready_idle", bus1.in_ready, 1'b1);
      chk("md1_done_idle", bus1.md_done, 1'b0);

      // random traffic
      for (int n = 0; n < 300; n++) begin
         p  = $urandom_range(0, 9);
         op = (p > 7) ? 3'b010 : 3'(p);
         fn = 6'($urandom);
         if (op == 3'b010 && $urandom_range(0, 3) != 0)
            fn = r_fn[$urandom_range(0, 11)];
         tick($urandom_range(0, 3) != 0, op, fn);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
